// File: rtl/adder_pkg.sv
// Shared types for the adder_4bit result path.
package adder_pkg;

    localparam int IN_W = 5;

    typedef logic [IN_W-1:0] adder_res_t;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} acc_state_e;

endpackage

// File: rtl/adder_result_accumulator_if.sv
// Result input plus burst-total output port of the accumulator.
interface adder_result_accumulator_if #(
    parameter int SUM_W = 7,
    parameter int CNT_W = 8
);
    import adder_pkg::*;

    logic             valid;
    adder_res_t       c;
    logic             out_ready;
    logic             out_valid;
    logic [SUM_W-1:0] out_sum;
    logic             out_ovf;
    logic             drop_err;
    logic [CNT_W-1:0] burst_cnt;

    modport master (
        output valid, c, out_ready,
        input  out_valid, out_sum, out_ovf, drop_err, burst_cnt
    );

    modport slave (
        input  valid, c, out_ready,
        output out_valid, out_sum, out_ovf, drop_err, burst_cnt
    );

endinterface

// File: rtl/sat_adder.sv
// Zero-extending unsigned adder clamped to 2**S_W-1; sat flags the clamp.
module sat_adder #(
    parameter int A_W = 5,
    parameter int S_W = 7
) (
    input  logic [S_W-1:0] a,
    input  logic [A_W-1:0] b,
    output logic [S_W-1:0] sum,
    output logic           sat
);
    localparam int W_W = ((A_W > S_W) ? A_W : S_W) + 1;
    localparam logic [W_W-1:0] SAT_MAX = {{(W_W-S_W){1'b0}}, {S_W{1'b1}}};

    logic [W_W-1:0] wide_s;

    // Full-width sum, then clamp to the S_W-bit maximum
    always_comb begin
        wide_s = W_W'(a) + W_W'(b);
        if (wide_s > SAT_MAX) begin
            sum = SAT_MAX[S_W-1:0];
            sat = 1'b1;
        end else begin
            sum = wide_s[S_W-1:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/adder_result_accumulator.sv
// Sums BURST_LEN adder results per burst and offers each total on a valid/ready port.
// Accumulation never stalls; a total that finds the output still occupied is dropped.
module adder_result_accumulator
    import adder_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int SUM_W     = 7,
    parameter int CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    adder_result_accumulator_if.slave  bus
);
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);

    logic [SUM_W-1:0] acc_r;
    logic [CW-1:0]    cnt_r;
    logic             acc_ovf_r;
    acc_state_e       state_r;
    acc_state_e       state_nxt_s;
    logic [SUM_W-1:0] add_sum_s;
    logic             add_sat_s;
    logic             complete_s;
    logic             load_s;
    logic             accept_s;
    logic             drop_s;
    logic             out_valid_r;
    logic [SUM_W-1:0] out_sum_r;
    logic             out_ovf_r;
    logic             drop_err_r;
    logic [CNT_W-1:0] burst_cnt_r;

    // On the completing edge the same sum is both the burst total and the (discarded) acc update
    sat_adder #(.A_W(IN_W), .S_W(SUM_W)) u_sat_adder (
        .a   (acc_r),
        .b   (bus.c),
        .sum (add_sum_s),
        .sat (add_sat_s)
    );

    assign complete_s = bus.valid && (cnt_r == LAST_IDX);

    // Running burst accumulator and result counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r     <= '0;
            cnt_r     <= '0;
            acc_ovf_r <= 1'b0;
        end else if (complete_s) begin
            acc_r     <= '0;
            cnt_r     <= '0;
            acc_ovf_r <= 1'b0;
        end else if (bus.valid) begin
            acc_r     <= add_sum_s;
            cnt_r     <= cnt_r + CW'(1);
            acc_ovf_r <= acc_ovf_r | add_sat_s;
        end else begin
            acc_r     <= acc_r;
            cnt_r     <= cnt_r;
            acc_ovf_r <= acc_ovf_r;
        end
    end

    // Output-slot state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output-slot next state: load, handshake and drop decisions
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        accept_s    = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            EMPTY: begin
                if (complete_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    accept_s = 1'b1;
                    if (complete_s) begin
                        load_s      = 1'b1;
                        state_nxt_s = FULL;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end else if (complete_s) begin
                    drop_s      = 1'b1;
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // Registered outputs: held total, sticky drop flag, delivered-burst counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_sum_r   <= '0;
            out_ovf_r   <= 1'b0;
            drop_err_r  <= 1'b0;
            burst_cnt_r <= '0;
        end else begin
            out_valid_r <= (state_nxt_s == FULL);
            if (load_s) begin
                out_sum_r <= add_sum_s;
                out_ovf_r <= acc_ovf_r | add_sat_s;
            end else begin
                out_sum_r <= out_sum_r;
                out_ovf_r <= out_ovf_r;
            end
            drop_err_r  <= drop_err_r | drop_s;
            burst_cnt_r <= accept_s ? (burst_cnt_r + CNT_W'(1)) : burst_cnt_r;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = out_sum_r;
    assign bus.out_ovf   = out_ovf_r;
    assign bus.drop_err  = drop_err_r;
    assign bus.burst_cnt = burst_cnt_r;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Randomised and directed bench for adder_result_accumulator; a default-width
// instance and a SUM_W=5 instance share one stimulus stream.
module tb_adder_result_accumulator;
    import adder_pkg::*;

    localparam int BL = 4;

    logic clk;
    logic reset;

    adder_result_accumulator_if #(.SUM_W(7), .CNT_W(8)) if0 ();
    adder_result_accumulator_if #(.SUM_W(5), .CNT_W(8)) if5 ();

    adder_result_accumulator #(.BURST_LEN(BL), .SUM_W(7), .CNT_W(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    adder_result_accumulator #(.BURST_LEN(BL), .SUM_W(5), .CNT_W(8)) u_dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (if5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: burst content kept as plain integer sum and count
    int part_sum [2];
    int part_n   [2];
    bit held_v   [2];
    int held_sum [2];
    bit held_ovf [2];
    bit drop     [2];
    int bcnt     [2];
    int maxv     [2] = '{127, 31};

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            part_sum[k] = 0;
            part_n[k]   = 0;
            held_v[k]   = 1'b0;
            held_sum[k] = 0;
            held_ovf[k] = 1'b0;
            drop[k]     = 1'b0;
            bcnt[k]     = 0;
        end
    endtask

    task automatic model_edge(input bit v, input int cv, input bit rdy);
        for (int k = 0; k < 2; k++) begin
            bit done;
            int tot;
            done = v && (part_n[k] == BL - 1);
            tot  = 0;
            if (v) begin
                part_sum[k] += cv;
                part_n[k]++;
            end
            if (done) begin
                tot         = part_sum[k];
                part_sum[k] = 0;
                part_n[k]   = 0;
            end
            if (held_v[k] && rdy) begin
                bcnt[k]   = (bcnt[k] + 1) % 256;
                held_v[k] = 1'b0;
            end
            if (done) begin
                if (held_v[k]) begin
                    drop[k] = 1'b1;
                end else begin
                    held_v[k]   = 1'b1;
                    held_sum[k] = (tot > maxv[k]) ? maxv[k] : tot;
                    held_ovf[k] = (tot > maxv[k]);
                end
            end
        end
    endtask

    task automatic check_all(input bit after_reset);
        check_val("d0_valid", if0.out_valid, held_v[0]);
        check_val("d0_drop",  if0.drop_err,  drop[0]);
        check_val("d0_bcnt",  if0.burst_cnt, bcnt[0]);
        if (held_v[0] || after_reset) begin
            check_val("d0_sum", if0.out_sum, held_sum[0]);
            check_val("d0_ovf", if0.out_ovf, held_ovf[0]);
        end
        check_val("d5_valid", if5.out_valid, held_v[1]);
        check_val("d5_drop",  if5.drop_err,  drop[1]);
        check_val("d5_bcnt",  if5.burst_cnt, bcnt[1]);
        if (held_v[1] || after_reset) begin
            check_val("d5_sum", if5.out_sum, held_sum[1]);
            check_val("d5_ovf", if5.out_ovf, held_ovf[1]);
        end
    endtask

    task automatic drive(input bit v, input int cv, input bit rdy);
        if0.valid = v;  if0.c = adder_res_t'(cv);  if0.out_ready = rdy;
        if5.valid = v;  if5.c = adder_res_t'(cv);  if5.out_ready = rdy;
    endtask

    // One clock: drive, let the edge happen, update model, compare just after the edge
    task automatic step(input bit v, input int cv, input bit rdy);
        drive(v, cv, rdy);
        @(posedge clk);
        model_edge(v, cv, rdy);
        #1;
        check_all(1'b0);
    endtask

    // Asynchronous reset pulse asserted between edges; outputs must clear before any clock
    task automatic do_reset();
        drive(1'b0, 0, 1'b0);
        reset = 1'b1;
        #2;
        model_reset();
        check_all(1'b1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        drive(1'b0, 0, 1'b0);
        reset = 1'b1;
        #3;
        model_reset();
        check_all(1'b1);
        @(negedge clk);
        reset = 1'b0;

        // Basic burst 3+5+7+9 with consumer ready
        step(1'b1, 3, 1'b1);
        step(1'b1, 5, 1'b1);
        step(1'b1, 7, 1'b1);
        step(1'b1, 9, 1'b1);
        check_val("t1_valid", if0.out_valid, 1);
        check_val("t1_sum",   if0.out_sum, 24);
        step(1'b0, 0, 1'b1);
        check_val("t1_bcnt",  if0.burst_cnt, 1);

        // Valid gaps ignored, c garbage during gaps
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 31, 1'b0);
            if (i < 3) begin
                step(1'b0, int'($urandom_range(0, 31)), 1'b0);
                step(1'b0, int'($urandom_range(0, 31)), 1'b0);
            end
        end
        check_val("t2_sum", if0.out_sum, 124);
        check_val("t2_ovf", if0.out_ovf, 0);
        step(1'b0, 0, 1'b1);

        // Second burst while first is held is dropped
        step(1'b1, 1, 1'b0);  step(1'b1, 2, 1'b0);  step(1'b1, 3, 1'b0);  step(1'b1, 4, 1'b0);
        step(1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 5, 1'b0);
        check_val("t3_sum",  if0.out_sum, 10);
        check_val("t3_drop", if0.drop_err, 1);
        step(1'b0, 0, 1'b1);
        check_val("t3_bcnt",  if0.burst_cnt, 3);
        check_val("t3_empty", if0.out_valid, 0);

        // Handshake on the same edge a new burst completes
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 3, 1'b0);
        step(1'b1, 3, 1'b1);
        check_val("t4_valid", if0.out_valid, 1);
        check_val("t4_sum",   if0.out_sum, 12);
        check_val("t4_bcnt",  if0.burst_cnt, 1);
        check_val("t4_drop",  if0.drop_err, 0);

        // Reset mid-burst while a total is held
        step(1'b1, 6, 1'b0);
        step(1'b1, 6, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0);
        check_val("t6_sum", if0.out_sum, 4);

        // Saturation on the narrow instance
        do_reset();
        step(1'b1, 31, 1'b0);  step(1'b1, 31, 1'b0);  step(1'b1, 0, 1'b0);  step(1'b1, 0, 1'b0);
        check_val("t5_sum5", if5.out_sum, 31);
        check_val("t5_ovf5", if5.out_ovf, 1);
        check_val("t5_sum7", if0.out_sum, 62);
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0);
        check_val("t5b_sum5", if5.out_sum, 4);
        check_val("t5b_ovf5", if5.out_ovf, 0);

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 65, int'($urandom_range(0, 31)),
                     $urandom_range(0, 99) < 50);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
